ms_job_scheduler: RTL and testbench
===================================

// Module: ms_job_scheduler
// PURPOSE
//  Shares one 15x15 BFS maze-solver core (MS) between N_REQ requesters.
//  Grants requesters round-robin, streams the granted 225-bit maze into the core,
//  and forwards its path/not-valid result tagged with the owner id.
//  Aborts a hung solve on timeout. Sits between the maze sources and the MS instance.
// PARAMETERS
//  N_REQ    4     number of requesters (2..8)
//  TIMEOUT  4096  cycles allowed from last maze bit to first ms_out_valid
// PORTS
//  clk             in   1      clock
//  rst             in   1      synchronous active-high reset
//  req             in   N_REQ  job request; held until the matching done pulse
//  gnt             out  N_REQ  one-hot owner; high from grant until done
//  src_addr        out  8      maze bit index 0..224, row-major, row 0 first
//  src_data        in   N_REQ  per-requester maze bit for src_addr, combinational
//  ms_rst_n        out  1      solver reset, active-low
//  ms_in_valid     out  1      solver in_valid
//  ms_maze         out  1      solver maze bit
//  ms_out_valid    in   1      solver out_valid
//  ms_not_valid    in   1      solver maze_not_valid
//  ms_x, ms_y      in   4      solver out_x / out_y
//  res_valid       out  1      path coordinate valid (1-cycle delay from ms_out_valid)
//  res_x, res_y    out  4      path coordinate, registered
//  res_id          out  3      owner index of the current result
//  done            out  1      1-cycle pulse at job end
//  fail            out  1      with done: maze has no path (solver-reported)
//  timeout         out  1      with done: solver hung and was reset
//  path_len        out  8      with done: number of res_valid beats
// BEHAVIOUR
//  Reset: all outputs 0 except ms_rst_n=0. rst asserted mid-job drops the job
//   silently (no done); ms_rst_n=0 while rst=1 and for one cycle after.
//  FSM: ARB -> LOAD -> WAIT -> RUN -> ARB; timeout path WAIT -> KILL -> ARB.
//  ARB: if any req, gnt = first requester at or after rr_ptr; rr_ptr <= winner+1
//   (mod N_REQ). Go to LOAD next cycle. Ties resolve by rotation only, never fixed priority.
//  LOAD: 225 contiguous cycles. src_addr = 0..224;
//   ms_maze <= src_data[owner], ms_in_valid <= 1 (registered, 1-cycle skew).
//   Never gap in_valid: the core clears its bit count on a gap.
//   req drop during LOAD is ignored; the load completes.
//  WAIT: 12-bit counter from 0. ms_out_valid=1 -> RUN.
//   Counter reaching TIMEOUT-1 -> KILL.
//  RUN: forward ms_x/ms_y as res_x/res_y with res_valid; path_len increments per beat
//   (saturates 255).
//   ms_not_valid=1 on the first beat -> fail=1, res_valid stays 0, path_len=0.
//   First cycle with ms_out_valid=0 -> done pulse; gnt clears the same cycle; back to ARB.
//   ARB may grant again the next cycle. Path order is goal (13,13) to start (1,1).
//  KILL: ms_rst_n=0 for 2 cycles, then done with timeout=1, fail=1; back to ARB.
//  gnt must never change outside ARB; req of a non-owner is not sampled outside ARB.
//  Minimum job spacing: done -> next ms_in_valid >= 2 cycles (core returns to IDLE).
// STRUCTURE
//  Package ms_pkg: sched_state_e enum, MAZE_BITS=225, MAZE_DIM=15, coord_t (logic[3:0]).
//  Sub-module rr_arbiter (N_REQ, one-hot out, rotating pointer, advance-on-grant).
//  Top: FSM, load/timeout counters, result register slice. Target 150-250 lines.
// TESTING
//  1 Single req[0], open maze (border walls only) -> 225 in_valid cycles, contiguous
//    res beats from (13,13) to (1,1); path_len=25; done, fail=0.
//  2 req=4'b1111 held -> grant order 0,1,2,3,0; res_id matches each gnt.
//  3 Maze with wall at core start cell -> single beat with ms_not_valid -> done, fail=1,
//    path_len=0, res_valid never 1.
//  4 Solver model silent after load -> KILL at TIMEOUT; ms_rst_n low 2 cycles;
//    done with timeout=1; next job still served.
//  5 rst pulse in LOAD at bit 100 -> all outputs reset, no done; restart reloads from bit 0.
//  6 req[owner] dropped mid-LOAD -> load completes, result and done still delivered.

Source files
------------

// File: rtl/ms_pkg.sv
// rtl/ms_pkg.sv - shared types and constants for the maze-solver job scheduler
package ms_pkg;

  localparam int MAZE_BITS = 225;
  localparam int MAZE_DIM  = 15;

  typedef logic [3:0] coord_t;

  typedef enum logic [2:0] {
    S_ARB,
    S_LOAD,
    S_WAIT,
    S_RUN,
    S_KILL
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-pointer round-robin arbiter, pointer advances past each winner
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       idx,
  output logic             any
);

  logic [2:0]       ptr_q, ptr_d;
  logic [N_REQ-1:0] rot;
  logic [2:0]       sel;
  logic [3:0]       sum;

  // Rotate so bit 0 is the pointer position; the first set bit is the winner.
  always_comb begin
    rot = N_REQ'({req, req} >> ptr_q);
    any = 1'b0;
    sel = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        sel = 3'(i);
      end
    end
    sum = 4'(ptr_q) + 4'(sel);
    if (sum >= 4'(N_REQ)) begin
      sum = sum - 4'(N_REQ);
    end
    idx = 3'(sum);
    gnt = any ? (N_REQ'(1) << idx) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && any) begin
      ptr_d = (idx == 3'(N_REQ - 1)) ? 3'd0 : idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ms_job_scheduler.sv
// rtl/ms_job_scheduler.sv - shares one maze-solver core between requesters, with timeout abort
module ms_job_scheduler
  import ms_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [7:0]       src_addr,
  input  logic [N_REQ-1:0] src_data,
  output logic             ms_rst_n,
  output logic             ms_in_valid,
  output logic             ms_maze,
  input  logic             ms_out_valid,
  input  logic             ms_not_valid,
  input  logic [3:0]       ms_x,
  input  logic [3:0]       ms_y,
  output logic             res_valid,
  output logic [3:0]       res_x,
  output logic [3:0]       res_y,
  output logic [2:0]       res_id,
  output logic             done,
  output logic             fail,
  output logic             timeout,
  output logic [7:0]       path_len
);

  localparam logic [11:0] LOAD_LAST = 12'(MAZE_BITS - 1);
  localparam logic [11:0] TMO_LAST  = 12'(TIMEOUT - 1);

  sched_state_e     state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       owner_q, owner_d;
  logic [11:0]      cnt_q, cnt_d;
  logic             maze_q, maze_d;
  logic             in_valid_q, in_valid_d;
  logic             rstn_q, rstn_d;
  logic             res_valid_q, res_valid_d;
  coord_t           res_x_q, res_x_d, res_y_q, res_y_d;
  logic [7:0]       plen_q, plen_d;
  logic             nv_q, nv_d;
  logic             done_q, done_d, fail_q, fail_d, tmo_q, tmo_d;

  logic             arb_adv, arb_any;
  logic [N_REQ-1:0] arb_gnt;
  logic [2:0]       arb_idx;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .advance(arb_adv),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    maze_d      = 1'b0;
    in_valid_d  = 1'b0;
    rstn_d      = 1'b1;
    res_valid_d = 1'b0;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    plen_d      = plen_q;
    nv_d        = nv_q;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    tmo_d       = 1'b0;
    arb_adv     = 1'b0;
    case (state_q)
      S_ARB: begin
        if (arb_any) begin
          arb_adv = 1'b1;
          gnt_d   = arb_gnt;
          owner_d = arb_idx;
          cnt_d   = 12'd0;
          plen_d  = 8'd0;
          nv_d    = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // The core drops its bit count on any in_valid gap, so the load never stalls.
        maze_d     = |(src_data & gnt_q);
        in_valid_d = 1'b1;
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = 12'd0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_WAIT: begin
        if (ms_out_valid) begin
          state_d = S_RUN;
          if (ms_not_valid) begin
            nv_d = 1'b1;
          end else begin
            res_valid_d = 1'b1;
            res_x_d     = ms_x;
            res_y_d     = ms_y;
            plen_d      = 8'd1;
          end
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = 12'd0;
          rstn_d  = 1'b0;
          state_d = S_KILL;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_RUN: begin
        if (ms_out_valid) begin
          if (!nv_q) begin
            res_valid_d = 1'b1;
            res_x_d     = ms_x;
            res_y_d     = ms_y;
            plen_d      = (plen_q == 8'hFF) ? plen_q : plen_q + 8'd1;
          end
        end else begin
          done_d  = 1'b1;
          fail_d  = nv_q;
          gnt_d   = '0;
          state_d = S_ARB;
        end
      end
      S_KILL: begin
        rstn_d = 1'b0;
        if (cnt_q == 12'd1) begin
          rstn_d  = 1'b1;
          done_d  = 1'b1;
          fail_d  = 1'b1;
          tmo_d   = 1'b1;
          gnt_d   = '0;
          state_d = S_ARB;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: state_d = S_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ARB;
      gnt_q       <= '0;
      owner_q     <= 3'd0;
      cnt_q       <= 12'd0;
      maze_q      <= 1'b0;
      in_valid_q  <= 1'b0;
      rstn_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      plen_q      <= 8'd0;
      nv_q        <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      maze_q      <= maze_d;
      in_valid_q  <= in_valid_d;
      rstn_q      <= rstn_d;
      res_valid_q <= res_valid_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      plen_q      <= plen_d;
      nv_q        <= nv_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      tmo_q       <= tmo_d;
    end
  end

  // rstn_q is cleared by rst, which holds the core in reset one cycle past rst release.
  assign ms_rst_n    = rstn_q & ~rst;
  assign gnt         = gnt_q;
  assign src_addr    = (state_q == S_LOAD) ? cnt_q[7:0] : 8'd0;
  assign ms_in_valid = in_valid_q;
  assign ms_maze     = maze_q;
  assign res_valid   = res_valid_q;
  assign res_x       = res_x_q;
  assign res_y       = res_y_q;
  assign res_id      = owner_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign timeout     = tmo_q;
  assign path_len    = plen_q;

endmodule

// File: tb/tb_ms_job_scheduler.sv
// tb/tb_ms_job_scheduler.sv - directed bench for ms_job_scheduler with a behavioural solver core
module tb_ms_job_scheduler;

  localparam int N   = 4;
  localparam int TMO = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] req, gnt, src_data;
  logic [7:0]   src_addr;
  logic         ms_rst_n, ms_in_valid, ms_maze, ms_out_valid, ms_not_valid;
  logic [3:0]   ms_x, ms_y, res_x, res_y;
  logic         res_valid, done, fail, timeout;
  logic [2:0]   res_id;
  logic [7:0]   path_len;

  ms_job_scheduler #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .src_addr(src_addr), .src_data(src_data),
    .ms_rst_n(ms_rst_n), .ms_in_valid(ms_in_valid), .ms_maze(ms_maze),
    .ms_out_valid(ms_out_valid), .ms_not_valid(ms_not_valid), .ms_x(ms_x), .ms_y(ms_y),
    .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .res_id(res_id),
    .done(done), .fail(fail), .timeout(timeout), .path_len(path_len)
  );

  logic [224:0] maze_mem [N];

  always_comb begin
    for (int r = 0; r < N; r++) begin
      src_data[r] = (src_addr < 8'd225) ? maze_mem[r][src_addr] : 1'b0;
    end
  end

  function automatic int ex(input int b);
    return (b < 13) ? 13 - b : 1;
  endfunction

  function automatic int ey(input int b);
    return (b < 13) ? 13 : 25 - b;
  endfunction

  function automatic logic [224:0] build_maze(input int seed);
    logic [224:0] m;
    m = '0;
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 15; c++) begin
        if (r == 0 || r == 14 || c == 0 || c == 14) m[r*15+c] = 1'b1;
        else if (seed != 0 && ((r*7 + c*3 + seed) % 5 == 0)) m[r*15+c] = 1'b1;
      end
    end
    m[16]  = 1'b0;
    m[208] = 1'b0;
    return m;
  endfunction

  // Solver core: collects 225 contiguous bits, then after a short delay emits the
  // 25-cell path (13,13)->(1,1), or one not-valid beat if the start cell is a wall.
  int           m_phase = 0, m_cnt = 0, m_delay = 0, m_beat = 0;
  bit           m_silent = 1'b0;
  logic [224:0] m_rx = '0;

  initial begin
    ms_out_valid = 1'b0; ms_not_valid = 1'b0; ms_x = 4'd0; ms_y = 4'd0;
    forever begin
      @(posedge clk); #1;
      ms_out_valid = 1'b0; ms_not_valid = 1'b0;
      if (!ms_rst_n) begin
        m_phase = 0; m_cnt = 0;
      end else begin
        case (m_phase)
          0: begin
            if (ms_in_valid) begin
              m_rx[m_cnt] = ms_maze;
              m_cnt++;
              if (m_cnt == 225) begin m_phase = 1; m_delay = 0; end
            end else m_cnt = 0;
          end
          1: begin
            if (!m_silent) begin
              m_delay++;
              if (m_delay == 4) begin m_phase = 2; m_beat = 0; end
            end
          end
          default: begin
            ms_out_valid = 1'b1;
            if (m_rx[16]) begin
              ms_not_valid = 1'b1; m_phase = 0; m_cnt = 0;
            end else begin
              ms_x = 4'(ex(m_beat)); ms_y = 4'(ey(m_beat));
              m_beat++;
              if (m_beat == 25) begin m_phase = 0; m_cnt = 0; end
            end
          end
        endcase
      end
    end
  end

  int         cyc = 0, iv_n = 0, iv_r = 0, bn = 0, br = 0, dn = 0, gn = 0, rstl = 0;
  int         iv_last = 0, d_cyc = 0;
  logic       d_fail = 1'b0, d_to = 1'b0;
  logic [7:0] d_len = 8'd0;
  logic [3:0] bx [1024], by [1024];
  logic [2:0] bid [1024];
  logic [N-1:0] gseq [64];

  initial begin
    logic prev_iv, prev_rv;
    logic [N-1:0] prev_gnt;
    prev_iv = 1'b0; prev_rv = 1'b0; prev_gnt = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ms_in_valid) begin
        iv_n++; iv_last = cyc;
        if (!prev_iv) iv_r++;
      end
      if (res_valid && bn < 1024) begin
        bx[bn] = res_x; by[bn] = res_y; bid[bn] = res_id; bn++;
        if (!prev_rv) br++;
      end
      if (done) begin dn++; d_cyc = cyc; d_fail = fail; d_to = timeout; d_len = path_len; end
      if (!ms_rst_n) rstl++;
      if (gnt != prev_gnt && gnt != '0 && gn < 64) begin gseq[gn] = gnt; gn++; end
      prev_iv = ms_in_valid; prev_rv = res_valid; prev_gnt = gnt;
    end
  end

  int n_cmp = 0, n_bad = 0;
  int bn0, ivn0, ivr0, br0, dn0, gn0, rstl0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    bn0 = bn; ivn0 = iv_n; ivr0 = iv_r; br0 = br; dn0 = dn; gn0 = gn; rstl0 = rstl;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (dn == dn0 && k < budget) begin @(negedge clk); #1; k++; end
    chk({tag, "_done"}, dn - dn0, 1);
  endtask

  task automatic wait_addr(input string tag, input logic [7:0] a);
    int k;
    k = 0;
    while (src_addr != a && k < 400) begin @(negedge clk); k++; end
    chk({tag, "_addr"}, src_addr, a);
  endtask

  task automatic check_path(input string tag, input int owner);
    int n, bad_xy, bad_id;
    n = bn - bn0; bad_xy = 0; bad_id = 0;
    if (n > 25) n = 25;
    for (int b = 0; b < n; b++) begin
      if (bx[bn0+b] !== 4'(ex(b)) || by[bn0+b] !== 4'(ey(b))) bad_xy++;
      if (bid[bn0+b] !== 3'(owner)) bad_id++;
    end
    chk({tag, "_iv_count"}, iv_n - ivn0, 225);
    chk({tag, "_iv_runs"}, iv_r - ivr0, 1);
    chk({tag, "_maze"}, 32'(m_rx === maze_mem[owner]), 1);
    chk({tag, "_beats"}, bn - bn0, 25);
    chk({tag, "_beat_runs"}, br - br0, 1);
    chk({tag, "_xy_bad"}, bad_xy, 0);
    chk({tag, "_id_bad"}, bad_id, 0);
    chk({tag, "_path_len"}, d_len, 25);
    chk({tag, "_fail"}, d_fail, 0);
    chk({tag, "_timeout"}, d_to, 0);
  endtask

  int exp_o [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; req = '0;
    maze_mem[0] = build_maze(0);
    maze_mem[1] = build_maze(1);
    maze_mem[2] = build_maze(2);
    maze_mem[3] = build_maze(3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_ms_rst_n", ms_rst_n, 0);
    chk("rst_in_valid", ms_in_valid, 0);
    chk("rst_maze", ms_maze, 0);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_path_len", path_len, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_n_hold", ms_rst_n, 0);
    @(negedge clk); #1;
    chk("rst_n_release", ms_rst_n, 1);

    // round-robin order with all requesters held
    snap();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done($sformatf("t2_job%0d", k), 900);
      if (k == 4) req = '0;
      chk($sformatf("t2_gnt%0d", k), gseq[gn0], 32'(1 << exp_o[k]));
      check_path($sformatf("t2_job%0d", k), exp_o[k]);
      snap();
    end

    // single requester, open maze, pointer wraps back to 0
    req = 4'b0001;
    wait_done("t1", 900);
    req = '0;
    chk("t1_gnt", gseq[gn0], 4'b0001);
    check_path("t1", 0);

    // wall at start cell
    maze_mem[2][16] = 1'b1;
    snap();
    req = 4'b0100;
    wait_done("t3", 900);
    req = '0;
    chk("t3_fail", d_fail, 1);
    chk("t3_timeout", d_to, 0);
    chk("t3_path_len", d_len, 0);
    chk("t3_beats", bn - bn0, 0);
    chk("t3_maze", 32'(m_rx === maze_mem[2]), 1);

    // silent core -> kill after TIMEOUT, then the next job is served
    m_silent = 1'b1;
    snap();
    req = 4'b0001;
    wait_done("t4", TMO + 600);
    req = '0;
    m_silent = 1'b0;
    chk("t4_timeout", d_to, 1);
    chk("t4_fail", d_fail, 1);
    chk("t4_rstn_low", rstl - rstl0, 2);
    chk("t4_latency", d_cyc - iv_last, TMO + 2);
    chk("t4_beats", bn - bn0, 0);
    snap();
    req = 4'b0010;
    wait_done("t4_next", 900);
    req = '0;
    check_path("t4_next", 1);

    // reset mid-load at bit 100
    snap();
    req = 4'b1000;
    wait_addr("t5", 8'd100);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_gnt", gnt, 0);
    chk("t5_in_valid", ms_in_valid, 0);
    chk("t5_ms_rst_n", ms_rst_n, 0);
    chk("t5_src_addr", src_addr, 0);
    chk("t5_done", done, 0);
    chk("t5_dn", dn - dn0, 0);
    rst = 1'b0;
    snap();
    wait_done("t5", 900);
    req = '0;
    check_path("t5", 3);

    // owner drops req mid-load
    snap();
    req = 4'b0010;
    wait_addr("t6", 8'd50);
    req = '0;
    wait_done("t6", 900);
    check_path("t6", 1);
    repeat (4) @(negedge clk);
    chk("t6_gnt_idle", gnt, 0);
    chk("t6_grants", gn - gn0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
